mem_request_scheduler: RTL and testbench
========================================

# mem_request_scheduler

Front-end scheduler between the four compute units and the shared-memory controller. Each unit pushes memory commands (op type, vector index, matrix row/col) into a private FIFO. The scheduler picks one command at a time in round-robin order and presents it on the controller's per-unit request lanes. It holds the request until the controller signals completion, then returns a response pulse to the originating unit.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries per unit command FIFO; power of two, 2..16.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles, 1..255; used only with SCHED_WATCHDOG_EN.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  [3:0]  per-unit command valid.
- cmd_ready  out  [3:0]  per-unit FIFO not full.
- cmd_op_type  in  [3:0][3:0]  op type; bit 3 = write.
- cmd_vec_index  in  [3:0][3:0]  vector index.
- cmd_mat_row  in  [3:0][3:0]  matrix row.
- cmd_mat_col  in  [3:0][3:0]  matrix column.
- rsp_valid  out  [3:0]  one-cycle completion pulse per unit.
- rsp_timeout  out  [3:0]  one-cycle pulse, coincident with rsp_valid, when the command was aborted by the watchdog.
- ctrl_request  out  [3:0]  one-hot request to the memory controller.
- ctrl_op_type, ctrl_vec_index, ctrl_mat_row, ctrl_mat_col  out  [3:0][3:0] each  issued command on the granted lane; all other lanes are 0.
- ctrl_done  in  [3:0]  controller done flags; may be sticky.
- sched_busy  out  1  high whenever the state is not IDLE.
- fifo_level  out  [3:0][4:0]  current occupancy per FIFO.

## Operation
- FIFOs: a command is pushed on lane i when cmd_valid[i] & cmd_ready[i]. cmd_ready[i] = (level < FIFO_DEPTH). A push and a pop on the same lane in the same cycle are both honoured; the level is unchanged.
- States: IDLE, ISSUE, RETIRE.
- IDLE: if any FIFO is non-empty:
  - Select lane by round-robin, searching from last_grant+1 mod 4.
  - Pop the head of the selected FIFO into the issue register.
  - Set last_grant to the selected lane.
  - Go to ISSUE.
- ISSUE:
  - ctrl_request[sel] = 1; command fields drive lane sel.
  - Completion is the rising edge of ctrl_done[sel], i.e. ctrl_done[sel] & ~done_q[sel], where done_q is ctrl_done registered every cycle. A stale high level does not complete.
  - On completion, go to RETIRE.
- RETIRE:
  - ctrl_request = 0; rsp_valid[sel] = 1 for this cycle.
  - Go to IDLE.
- ctrl_done on lanes other than sel is ignored.
- Reset: FIFOs empty, state IDLE, last_grant = 3 (so lane 0 is first), issue register 0, done_q 0. All outputs are 0 except cmd_ready = 4'hF.
- Reset asserted mid-operation drops the in-flight command and all queued commands; no rsp_valid is produced for them.

## Timing
- A push accepted at edge k can be popped at edge k+1 if the scheduler is in IDLE. ctrl_request rises after edge k+1.
- Completion edge seen at edge m: ctrl_request falls and rsp_valid pulses after edge m (RETIRE). State is IDLE after m+1. The next ctrl_request rises after m+2 at the earliest.
- Issue throughput is at most one command per 3 cycles plus controller latency.
- Outputs are registered, except cmd_ready, which is combinational from the FIFO level.
- Arbitration uses FIFO state as of the current cycle; a push in the same cycle is not visible.

## Configuration
- SCHED_WATCHDOG_EN defined:
  - An 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES before completion, go to RETIRE with rsp_valid[sel] = 1 and rsp_timeout[sel] = 1.
  - A completion edge in the same cycle wins; no timeout is flagged.
- SCHED_WATCHDOG_EN undefined: no counter; ISSUE waits indefinitely; rsp_timeout is tied to 0.

## Test plan
- Reset, then one read on lane 2 (op 4'h0, vec 3): ctrl_request = 4'b0100 one cycle after accept, with ctrl_vec_index[2] = 3. Pulse ctrl_done[2] three cycles later -> rsp_valid = 4'b0100 for exactly one cycle.
- All four lanes each push 2 commands at once -> issue order 0,1,2,3,0,1,2,3; rsp_valid pulses in the same order.
- Hold ctrl_done[1] high before issuing on lane 1 -> no completion until it falls and rises again.
- Fill lane 0 to FIFO_DEPTH = 4 while ISSUE is stalled -> cmd_ready[0] = 0 and fifo_level[0] = 4. A push attempt is dropped. After one retire, cmd_ready[0] returns to 1.
- With SCHED_WATCHDOG_EN and TIMEOUT_CYCLES = 10, never assert done -> rsp_valid[sel] and rsp_timeout[sel] pulse when the counter reaches 10; the next lane is then issued.
- Assert rst during ISSUE with 3 queued commands -> next cycle ctrl_request = 0, all fifo_level = 0, and no rsp_valid.

Source files
------------

// File: rtl/mem_request_scheduler.sv
`default_nettype none
// ============================================================================
// mem_request_scheduler: round-robin front end from four unit command FIFOs to
// the shared-memory controller. Optional watchdog: define SCHED_WATCHDOG_EN.
// Revision 1.0
// ============================================================================
module mem_request_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      cmd_valid,
  output logic [3:0]      cmd_ready,
  input  logic [3:0][3:0] cmd_op_type,
  input  logic [3:0][3:0] cmd_vec_index,
  input  logic [3:0][3:0] cmd_mat_row,
  input  logic [3:0][3:0] cmd_mat_col,
  output logic [3:0]      rsp_valid,
  output logic [3:0]      rsp_timeout,
  output logic [3:0]      ctrl_request,
  output logic [3:0][3:0] ctrl_op_type,
  output logic [3:0][3:0] ctrl_vec_index,
  output logic [3:0][3:0] ctrl_mat_row,
  output logic [3:0][3:0] ctrl_mat_col,
  input  logic [3:0]      ctrl_done,
  output logic            sched_busy,
  output logic [3:0][4:0] fifo_level
);

  localparam int         AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [1:0]       last_grant, last_grant_nxt;
  logic [15:0]      issue_cmd, issue_cmd_nxt;
  logic [3:0]       done_q;
  logic [3:0]       push, pop, not_empty;
  logic [3:0][15:0] head;
  logic             complete, timeout, found;
  logic [1:0]       cand;
  logic [3:0]       req_nxt, rsp_nxt, rto_nxt;
  logic [3:0][3:0]  op_nxt, vec_nxt, row_nxt, col_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    level;

    assign cmd_ready[i]  = (level < DEPTH);
    assign push[i]       = cmd_valid[i] & cmd_ready[i];
    assign not_empty[i]  = (level != 5'd0);
    assign head[i]       = mem[rd_ptr];
    assign fifo_level[i] = level;

    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem[wr_ptr] <= {cmd_op_type[i], cmd_vec_index[i], cmd_mat_row[i], cmd_mat_col[i]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   level <= level + 5'd1;
          2'b01:   level <= level - 5'd1;
          default: level <= level;
        endcase
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic [7:0] wd_cnt;

  // Held at zero outside ISSUE, so it restarts on every entry to ISSUE.
  always_ff @(posedge clk) begin
    if (rst || state != ISSUE) wd_cnt <= 8'd0;
    else                       wd_cnt <= wd_cnt + 8'd1;
  end

  assign timeout = (state == ISSUE) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    issue_cmd_nxt  = issue_cmd;
    pop            = '0;
    found          = 1'b0;
    cand           = '0;
    // Only a fresh rising edge on the granted lane completes; sticky levels do not.
    complete       = ctrl_done[sel] & ~done_q[sel];

    case (state)
      IDLE: begin
        for (int k = 1; k <= 4; k++) begin
          cand = last_grant + 2'(k);
          if (!found && not_empty[cand]) begin
            found   = 1'b1;
            sel_nxt = cand;
          end
        end
        if (found) begin
          pop[sel_nxt]   = 1'b1;
          last_grant_nxt = sel_nxt;
          issue_cmd_nxt  = head[sel_nxt];
          state_nxt      = ISSUE;
        end
      end
      ISSUE:   if (complete || timeout) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    req_nxt = '0;
    rsp_nxt = '0;
    rto_nxt = '0;
    op_nxt  = '0;
    vec_nxt = '0;
    row_nxt = '0;
    col_nxt = '0;
    if (state_nxt == ISSUE) begin
      req_nxt[sel_nxt] = 1'b1;
      op_nxt[sel_nxt]  = issue_cmd_nxt[15:12];
      vec_nxt[sel_nxt] = issue_cmd_nxt[11:8];
      row_nxt[sel_nxt] = issue_cmd_nxt[7:4];
      col_nxt[sel_nxt] = issue_cmd_nxt[3:0];
    end
    if (state_nxt == RETIRE) begin
      rsp_nxt[sel_nxt] = 1'b1;
      rto_nxt[sel_nxt] = timeout & ~complete;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= 2'd0;
      last_grant     <= 2'd3;
      issue_cmd      <= '0;
      done_q         <= '0;
      ctrl_request   <= '0;
      rsp_valid      <= '0;
      rsp_timeout    <= '0;
      ctrl_op_type   <= '0;
      ctrl_vec_index <= '0;
      ctrl_mat_row   <= '0;
      ctrl_mat_col   <= '0;
      sched_busy     <= 1'b0;
    end else begin
      state          <= state_nxt;
      sel            <= sel_nxt;
      last_grant     <= last_grant_nxt;
      issue_cmd      <= issue_cmd_nxt;
      done_q         <= ctrl_done;
      ctrl_request   <= req_nxt;
      rsp_valid      <= rsp_nxt;
      rsp_timeout    <= rto_nxt;
      ctrl_op_type   <= op_nxt;
      ctrl_vec_index <= vec_nxt;
      ctrl_mat_row   <= row_nxt;
      ctrl_mat_col   <= col_nxt;
      sched_busy     <= (state_nxt != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_request_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mem_request_scheduler: directed self-checking bench for the scheduler.
// Revision 1.0
// ============================================================================
module tb_mem_request_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      cmd_valid;
  logic [3:0]      cmd_ready;
  logic [3:0][3:0] cmd_op_type, cmd_vec_index, cmd_mat_row, cmd_mat_col;
  logic [3:0]      rsp_valid, rsp_timeout, ctrl_request, ctrl_done;
  logic [3:0][3:0] ctrl_op_type, ctrl_vec_index, ctrl_mat_row, ctrl_mat_col;
  logic            sched_busy;
  logic [3:0][4:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  mem_request_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_type(cmd_op_type), .cmd_vec_index(cmd_vec_index),
    .cmd_mat_row(cmd_mat_row), .cmd_mat_col(cmd_mat_col),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .ctrl_request(ctrl_request),
    .ctrl_op_type(ctrl_op_type), .ctrl_vec_index(ctrl_vec_index),
    .ctrl_mat_row(ctrl_mat_row), .ctrl_mat_col(ctrl_mat_col),
    .ctrl_done(ctrl_done), .sched_busy(sched_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int lane, input logic [3:0] op, input logic [3:0] vec,
                         input logic [3:0] row, input logic [3:0] col);
    cmd_op_type[lane]   = op;
    cmd_vec_index[lane] = vec;
    cmd_mat_row[lane]   = row;
    cmd_mat_col[lane]   = col;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = '0;
    ctrl_done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag, output int lane);
    int n = 0;
    while (ctrl_request == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(ctrl_request != 4'b0), 32'd1);
    lane = 0;
    for (int b = 0; b < 4; b++) if (ctrl_request[b]) lane = b;
  endtask

  task automatic finish_cmd(input string tag, input int lane);
    ctrl_done = 4'(1 << lane);
    tick();
    check({tag, "_rsp"}, 32'(rsp_valid), 32'(1 << lane));
    check({tag, "_req_drop"}, 32'(ctrl_request), 32'd0);
    ctrl_done = '0;
    tick();
    check({tag, "_rsp_once"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lane;
    int exp_lane;
    int n;
    logic seen;

    cmd_op_type   = '0;
    cmd_vec_index = '0;
    cmd_mat_row   = '0;
    cmd_mat_col   = '0;

    // Reset state
    rst       = 1'b1;
    cmd_valid = '0;
    ctrl_done = '0;
    tick();
    tick();
    check("rst_req",     32'(ctrl_request), 32'd0);
    check("rst_rsp",     32'(rsp_valid),    32'd0);
    check("rst_rto",     32'(rsp_timeout),  32'd0);
    check("rst_ready",   32'(cmd_ready),    32'hF);
    check("rst_level",   32'(fifo_level),   32'd0);
    check("rst_busy",    32'(sched_busy),   32'd0);
    rst = 1'b0;

    // Single read on lane 2
    set_cmd(2, 4'h0, 4'h3, 4'h1, 4'h2);
    cmd_valid = 4'b0100;
    tick();
    cmd_valid = '0;
    check("l2_level_after_push", 32'(fifo_level), 32'(5'd1) << 10);
    check("l2_no_req_yet",       32'(ctrl_request), 32'd0);
    tick();
    check("l2_req",   32'(ctrl_request),   32'h4);
    check("l2_vec",   32'(ctrl_vec_index), 32'h0300);
    check("l2_row",   32'(ctrl_mat_row),   32'h0100);
    check("l2_col",   32'(ctrl_mat_col),   32'h0200);
    check("l2_op",    32'(ctrl_op_type),   32'h0000);
    check("l2_busy",  32'(sched_busy),     32'd1);
    check("l2_popped", 32'(fifo_level),    32'd0);
    tick();
    tick();
    check("l2_req_held", 32'(ctrl_request), 32'h4);
    finish_cmd("l2", 2);
    check("l2_idle", 32'(sched_busy), 32'd0);

    // Round robin across all four lanes, two commands each
    do_reset();
    for (int l = 0; l < 4; l++) set_cmd(l, 4'(l), 4'(l), 4'h0, 4'h0);
    cmd_valid = 4'hF;
    tick();
    for (int l = 0; l < 4; l++) set_cmd(l, 4'h8, 4'(l + 4), 4'h0, 4'h0);
    tick();
    cmd_valid = '0;
    for (int k = 0; k < 8; k++) begin
      exp_lane = k % 4;
      wait_req("rr", lane);
      check($sformatf("rr%0d_lane", k), 32'(ctrl_request), 32'(1 << exp_lane));
      check($sformatf("rr%0d_vec", k),  32'(ctrl_vec_index), 32'(16'(k) << (4 * exp_lane)));
      finish_cmd($sformatf("rr%0d", k), exp_lane);
    end

    // Sticky done on lane 1 must not complete until it falls and rises again
    do_reset();
    ctrl_done = 4'b0010;
    set_cmd(1, 4'h8, 4'h5, 4'h6, 4'h7);
    cmd_valid = 4'b0010;
    tick();
    cmd_valid = '0;
    wait_req("sticky", lane);
    check("sticky_lane", 32'(ctrl_request), 32'h2);
    tick();
    tick();
    tick();
    check("sticky_still_req", 32'(ctrl_request), 32'h2);
    check("sticky_no_rsp",    32'(rsp_valid),    32'd0);
    ctrl_done = '0;
    tick();
    check("sticky_low_req", 32'(ctrl_request), 32'h2);
    finish_cmd("sticky", 1);

    // Fill lane 0 while the issued command stalls
    do_reset();
    cmd_valid = 4'b0001;
    for (int p = 0; p < 5; p++) begin
      set_cmd(0, 4'h0, 4'(p), 4'h0, 4'h0);
      tick();
    end
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(cmd_ready),  32'hE);
    check("full_issued_vec", 32'(ctrl_vec_index), 32'h0);
    set_cmd(0, 4'h0, 4'h9, 4'h0, 4'h0);
    tick();
    cmd_valid = '0;
    check("full_drop_level", 32'(fifo_level), 32'd4);
    finish_cmd("full_first", 0);
    tick();
    check("full_ready_back", 32'(cmd_ready),  32'hF);
    check("full_level_3",    32'(fifo_level), 32'd3);
    for (int p = 1; p < 5; p++) begin
      wait_req("drain", lane);
      check($sformatf("drain%0d_vec", p), 32'(ctrl_vec_index), 32'(p));
      finish_cmd($sformatf("drain%0d", p), 0);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ctrl_request != 4'b0) seen = 1'b1;
    end
    check("full_dropped_never_issued", 32'(seen), 32'd0);

`ifdef SCHED_WATCHDOG_EN
    // Watchdog abort after 10 ISSUE cycles, then the next lane issues
    do_reset();
    set_cmd(0, 4'h0, 4'hA, 4'h0, 4'h0);
    set_cmd(1, 4'h0, 4'hB, 4'h0, 4'h0);
    cmd_valid = 4'b0011;
    tick();
    cmd_valid = '0;
    wait_req("wd", lane);
    check("wd_lane", 32'(ctrl_request), 32'h1);
    n = 0;
    while (rsp_valid == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    check("wd_cycles",  32'(n),           32'd10);
    check("wd_rsp",     32'(rsp_valid),   32'h1);
    check("wd_timeout", 32'(rsp_timeout), 32'h1);
    wait_req("wd_next", lane);
    check("wd_next_lane", 32'(ctrl_request), 32'h2);
    finish_cmd("wd_next", 1);
`else
    n = 0;
`endif

    // Reset during ISSUE with three commands queued
    do_reset();
    for (int l = 0; l < 4; l++) set_cmd(l, 4'h0, 4'(l), 4'h0, 4'h0);
    cmd_valid = 4'hF;
    tick();
    cmd_valid = '0;
    tick();
    check("midrst_req_before", 32'(ctrl_request), 32'h1);
    check("midrst_queued",     32'(fifo_level),   {12'd0, 5'd1, 5'd1, 5'd1, 5'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_req",   32'(ctrl_request), 32'd0);
    check("midrst_level", 32'(fifo_level),   32'd0);
    check("midrst_rsp",   32'(rsp_valid),    32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid != 4'b0 || ctrl_request != 4'b0) seen = 1'b1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
